// File: rtl/timer_generic.sv
// timer_generic
//   Parametrised timer/counter channel: free-running prescaler, Normal /
//   CTC / Fast-PWM counting, write-one-to-clear overflow and compare flags,
//   and per-source interrupt requests.
//
//   Optional feature macro: TIMER_PWM_EN
//     defined   : OC_out waveform output, COM field in TCCR, OCR double
//                 buffering in Fast PWM.
//     undefined : no OC_out port, WGM 10 counts as Normal, TCCR[6:5] read 0.
//
// Ports
//   sysClock            system clock, all state changes on its rising edge
//   rst_n               asynchronous active-low reset
//   TCNT_input/_we      counter load (wins over a tick in the same cycle)
//   OCR_input/_we       compare buffer load
//   TCCR_input/_we      control: [2:0] CS, [4:3] WGM, [6:5] COM, [7] reserved
//   TIMSK_input/_we     interrupt masks: [0] TOIE, [1] OCIE
//   TIFR_input/_we      write-one-to-clear mask: [0] TOV, [1] OCF
//   TCNT_output         counter value
//   OCR_output          compare buffer value
//   TCCR_output         control register, bit 7 reads 0
//   TIMSK_output        mask register
//   TIFR_output         flag register
//   irq_ovf / irq_comp  flag AND mask, combinational
//   OC_out              waveform output (TIMER_PWM_EN only)

module timer_generic #(
  parameter int WIDTH         = 8,
  parameter int PRESCALE_BITS = 10
) (
  input  logic             sysClock,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] TCNT_input,
  input  logic             TCNT_write_enable,
  input  logic [WIDTH-1:0] OCR_input,
  input  logic             OCR_write_enable,
  input  logic [7:0]       TCCR_input,
  input  logic             TCCR_write_enable,
  input  logic [1:0]       TIMSK_input,
  input  logic             TIMSK_write_enable,
  input  logic [1:0]       TIFR_input,
  input  logic             TIFR_write_enable,
  output logic [WIDTH-1:0] TCNT_output,
  output logic [WIDTH-1:0] OCR_output,
  output logic [7:0]       TCCR_output,
  output logic [1:0]       TIMSK_output,
  output logic [1:0]       TIFR_output,
  output logic             irq_ovf,
  output logic             irq_comp
`ifdef TIMER_PWM_EN
  ,
  output logic             OC_out
`endif
);

  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

  localparam logic [1:0] WGM_CTC  = 2'b01;
  localparam logic [1:0] WGM_FPWM = 2'b10;

  // Clock-select decode: a divided tick fires when the low log2(N)
  // prescaler bits are all ones, so every divider shares one counter.
  function automatic logic tick_sel(input logic [2:0] sel, input logic [9:0] pre);
    case (sel)
      3'b001:  tick_sel = 1'b1;
      3'b010:  tick_sel = &pre[2:0];
      3'b011:  tick_sel = &pre[5:0];
      3'b100:  tick_sel = &pre[7:0];
      3'b101:  tick_sel = &pre[9:0];
      default: tick_sel = 1'b0;
    endcase
  endfunction

  logic [PRESCALE_BITS-1:0] presc;
  logic [WIDTH-1:0]         tcnt;
  logic [WIDTH-1:0]         tcnt_nxt;
  logic [WIDTH-1:0]         ocr_buf;
  logic [WIDTH-1:0]         cmp_val;
  logic [2:0]               cs;
  logic [1:0]               wgm;
  logic [1:0]               timsk;
  logic [1:0]               tifr;
  logic [1:0]               tifr_nxt;
  logic [1:0]               tifr_clr;
  logic                     tick;
  logic                     step;
  logic                     match;
  logic                     wrap;
  logic                     pwm_mode;
  logic                     unused_tccr;

  assign tick  = tick_sel(cs, presc[9:0]);
  // A CPU write to TCNT suppresses the tick update and its flags.
  assign step  = tick & ~TCNT_write_enable;
  assign match = step & (tcnt == cmp_val);
  assign wrap  = step & (tcnt == MAX);

`ifdef TIMER_PWM_EN
  logic [WIDTH-1:0] ocr_act;
  logic [1:0]       com;
  logic             oc;
  logic             oc_nxt;

  assign pwm_mode = (wgm == WGM_FPWM);
  // Fast PWM compares against the latched copy; other modes see the buffer.
  assign cmp_val  = pwm_mode ? ocr_act : ocr_buf;

  always_comb begin
    oc_nxt = oc;
    if (com == 2'b00) begin
      oc_nxt = 1'b0;
    end else if (pwm_mode) begin
      // Wrap is tested first so it wins when OCR == MAX.
      case (com)
        2'b10: begin
          if (wrap)       oc_nxt = 1'b1;
          else if (match) oc_nxt = 1'b0;
        end
        2'b11: begin
          if (wrap)       oc_nxt = 1'b0;
          else if (match) oc_nxt = 1'b1;
        end
        default: oc_nxt = 1'b0;
      endcase
    end else if (match) begin
      case (com)
        2'b01:   oc_nxt = ~oc;
        2'b10:   oc_nxt = 1'b0;
        default: oc_nxt = 1'b1;
      endcase
    end
  end

  always_ff @(posedge sysClock or negedge rst_n) begin
    if (!rst_n) begin
      ocr_act <= '0;
      com     <= 2'b00;
      oc      <= 1'b0;
    end else begin
      if (pwm_mode) begin
        if (wrap) ocr_act <= ocr_buf;
      end else begin
        ocr_act <= OCR_write_enable ? OCR_input : ocr_buf;
      end
      if (TCCR_write_enable) com <= TCCR_input[6:5];
      oc <= oc_nxt;
    end
  end

  assign OC_out      = oc;
  assign TCCR_output = {1'b0, com, wgm, cs};
  assign unused_tccr = TCCR_input[7];
`else
  assign pwm_mode    = 1'b0;
  assign cmp_val     = ocr_buf;
  assign TCCR_output = {3'b000, wgm, cs};
  assign unused_tccr = ^TCCR_input[7:5];
`endif

  always_comb begin
    tcnt_nxt = tcnt;
    if (TCNT_write_enable) begin
      tcnt_nxt = TCNT_input;
    end else if (step) begin
      if ((wgm == WGM_CTC) && match) tcnt_nxt = '0;
      else                           tcnt_nxt = tcnt + WIDTH'(1);
    end
  end

  // Hardware set is ORed in after the clear, so a simultaneous set wins.
  assign tifr_clr = TIFR_write_enable ? TIFR_input : 2'b00;
  assign tifr_nxt = (tifr & ~tifr_clr) | {match, wrap};

  always_ff @(posedge sysClock or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      tcnt    <= '0;
      ocr_buf <= '0;
      cs      <= 3'b000;
      wgm     <= 2'b00;
      timsk   <= 2'b00;
      tifr    <= 2'b00;
    end else begin
      presc <= presc + PRESCALE_BITS'(1);
      tcnt  <= tcnt_nxt;
      if (OCR_write_enable) ocr_buf <= OCR_input;
      if (TCCR_write_enable) begin
        cs  <= TCCR_input[2:0];
        wgm <= TCCR_input[4:3];
      end
      if (TIMSK_write_enable) timsk <= TIMSK_input;
      tifr <= tifr_nxt;
    end
  end

  assign TCNT_output  = tcnt;
  assign OCR_output   = ocr_buf;
  assign TIMSK_output = timsk;
  assign TIFR_output  = tifr;
  assign irq_ovf      = tifr[0] & timsk[0];
  assign irq_comp     = tifr[1] & timsk[1];

endmodule

// File: doc/timer_generic.md
Name: timer_generic

Overview:
Parametrised timer/counter that succeeds the fixed 8-bit and 16-bit timers in the ATmega32A emulator top level.
- Counter width is a parameter.
- Adds a shared-style free-running prescaler, Normal/CTC/Fast-PWM modes and write-one-to-clear interrupt flags.
- Adds per-source interrupt request outputs.
- Instantiated by the top level once per timer channel. Flag outputs are ORed into the joint TIFR.

Parameters:
WIDTH, 8, counter/compare register width in bits (8 or 16 used; any value 2..16 legal); MAX = 2^WIDTH-1.
PRESCALE_BITS, 10, prescaler counter width; must be >= 10 to support /1024.

Ports:
sysClock  input  1  system clock (16 MHz)
rst_n  input  1  asynchronous active-low reset
TCNT_input  input  WIDTH  new counter value
TCNT_write_enable  input  1  load TCNT_input this cycle
OCR_input  input  WIDTH  new compare value
OCR_write_enable  input  1  load OCR_input
TCCR_input  input  8  control: [2:0] CS, [4:3] WGM, [6:5] COM, [7] reserved
TCCR_write_enable  input  1  load TCCR_input
TIMSK_input  input  2  [0] TOIE, [1] OCIE
TIMSK_write_enable  input  1  load TIMSK_input
TIFR_input  input  2  write-one-to-clear mask: [0] TOV, [1] OCF
TIFR_write_enable  input  1  apply TIFR_input
TCNT_output  output  WIDTH  counter
OCR_output  output  WIDTH  OCR buffer value
TCCR_output  output  8  control register; bit 7 always reads 0
TIMSK_output  output  2  mask register
TIFR_output  output  2  flag register
irq_ovf  output  1  TIFR[0] & TIMSK[0]
irq_comp  output  1  TIFR[1] & TIMSK[1]
OC_out  output  1  waveform output (only with TIMER_PWM_EN)

Behaviour:
- Reset (asynchronous, rst_n=0): all registers, the prescaler and every output go to 0. The counter is stopped.
- Prescaler: free-running PRESCALE_BITS counter, incremented every cycle. It is never cleared by TCCR writes.
- Tick selection by CS:
  - 000 = no tick.
  - 001 = every cycle.
  - 010 /8, 011 /64, 100 /256, 101 /1024: tick when the low log2(N) prescaler bits are all 1.
  - 110/111 = reserved, no tick.
- WGM 00 Normal: on tick TCNT+1, MAX wraps to 0. TOV set on the tick where TCNT==MAX.
- WGM 01 CTC: on tick, if TCNT==OCR then TCNT->0, else TCNT+1.
  - TOV set only when TCNT==MAX wraps, i.e. OCR==MAX.
- WGM 10 Fast PWM: counts 0..MAX like Normal.
  - OCR is double-buffered: the buffer is loaded on write, and the active compare register takes the buffer on the tick that wraps MAX->0.
  - In other modes the active compare register equals the buffer immediately.
- WGM 11 reserved: behaves as Normal.
- Compare match (all modes): OCF set on a tick where TCNT equals the active compare value (value before update).
- TCNT write: the CPU write has priority over the tick update in that cycle. No TOV/OCF set that cycle.
- TIFR: a flag clears when TIFR_write_enable=1 and its mask bit is 1. Hardware set and clear in the same cycle leaves the flag set.
- Registers update on the sysClock rising edge. Outputs are registered values, visible the cycle after the write or tick.
- irq_* are combinational from TIFR/TIMSK.
- A TCCR write changing CS takes effect for ticks from the next cycle. The mode change does not touch TCNT.

Optional Feature:
TIMER_PWM_EN
- Defined: OC_out exists, reset 0. Behaviour by mode and COM:
  - Normal/CTC, COM 01: toggle on compare match.
  - Normal/CTC, COM 10: clear on compare match.
  - Normal/CTC, COM 11: set on compare match.
  - Fast PWM, COM 10 (non-inverting): clear on match, set on MAX->0 wrap.
  - Fast PWM, COM 11 (inverting): set on match, clear on wrap.
  - Fast PWM, COM 01: disconnected.
  - COM 00 in any mode: OC_out held 0.
  - If match and wrap occur on the same tick (OCR==MAX), wrap wins.
- Not defined: no OC_out port. WGM 10 behaves as Normal with no OCR double-buffering. TCCR[6:5] write-ignored and read 0.

Test Plan:
1. WIDTH=8, TCCR=0x01, TIMSK=01 -> TCNT counts 0..255 over 256 cycles; TOV and irq_ovf rise after the 255->0 tick. TIFR write 01 clears both next cycle.
2. WIDTH=8, CTC, OCR=9, CS=010 -> TCNT period 10 ticks = 80 cycles; OCF set each period; TOV never set.
3. WIDTH=16, TCNT write 0xFFFE while ticking at /1 -> TCNT reads 0xFFFE, then 0xFFFF, then 0x0000 with TOV set. No flag in the write cycle.
4. TIFR clear issued in the same cycle as a hardware TOV set -> TOV remains 1.
5. TIMER_PWM_EN, WIDTH=8, Fast PWM, COM=10, OCR=63, CS=001 -> OC_out high 64 cycles, low 192 per 256-cycle period. An OCR write to 127 mid-period takes effect only after the next wrap.
6. Assert rst_n low mid-count with CS=101 -> all outputs 0 immediately, without waiting for a clock edge. After release the counter stays stopped until TCCR is written.
